tlb_array_mp: RTL and testbench

TLB_ARRAY_MP -- requirements
Module: tlb_array_mp

---
 rtl/tlb_pkg.sv | 72 +++++++
 rtl/tlb_prio_enc.sv | 22 ++
 rtl/tlb_array_mp.sv | 206 ++++++++++++++++++++
 tb/tb_tlb_array_mp.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB types: 89-bit entry layout, 32-bit search result, invalidate op codes.
// Struct member order fixes the packed bit layout (first member is the MSB).
package tlb_pkg;

  localparam int VPPN_W  = 19;
  localparam int ASID_W  = 10;
  localparam int PS_W    = 6;
  localparam int PPN_W   = 20;
  localparam int MAT_W   = 2;
  localparam int PLV_W   = 2;
  localparam int ENTRY_W = 89;
  localparam int RES_W   = 32;

  localparam logic [PS_W-1:0] PS_4K = 6'd12;

  localparam logic [4:0] INV_OP_ALL0        = 5'd0;
  localparam logic [4:0] INV_OP_ALL1        = 5'd1;
  localparam logic [4:0] INV_OP_G1          = 5'd2;
  localparam logic [4:0] INV_OP_G0          = 5'd3;
  localparam logic [4:0] INV_OP_G0_ASID     = 5'd4;
  localparam logic [4:0] INV_OP_G0_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_OP_GASID_VA    = 5'd6;

  // One half-page: 26 bits
  typedef struct packed {
    logic             v;
    logic             d;
    logic [MAT_W-1:0] mat;
    logic [PLV_W-1:0] plv;
    logic [PPN_W-1:0] ppn;
  } tlb_half_t;

  typedef struct packed {
    logic [VPPN_W-1:0] vppn;
    logic [ASID_W-1:0] asid;
    logic              g;
    logic [PS_W-1:0]   ps;
    logic              e;
    tlb_half_t         p0;
    tlb_half_t         p1;
  } tlb_entry_t;

  typedef struct packed {
    logic [PS_W-1:0]  ps;
    logic [PPN_W-1:0] ppn;
    logic             v;
    logic             d;
    logic [MAT_W-1:0] mat;
    logic [PLV_W-1:0] plv;
  } tlb_res_t;

  typedef enum logic {INV_IDLE, INV_WALK} inv_state_t;

  // Large pages only compare the upper ten VPPN bits
  function automatic logic vpn_match(input logic [PS_W-1:0] ps,
                                     input logic [VPPN_W-1:0] a,
                                     input logic [VPPN_W-1:0] b);
    return (ps == PS_4K) ? (a == b) : (a[18:9] == b[18:9]);
  endfunction

  function automatic tlb_res_t half_res(input logic [PS_W-1:0] ps, input tlb_half_t h);
    tlb_res_t r;
    r.ps  = ps;
    r.ppn = h.ppn;
    r.v   = h.v;
    r.d   = h.d;
    r.mat = h.mat;
    r.plv = h.plv;
    return r;
  endfunction

endpackage

// File: rtl/tlb_prio_enc.sv
// Lowest-index priority encoder with any-hit and multi-hit flags.
module tlb_prio_enc #(
  parameter  int N = 32,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic         found,
  output logic         multi,
  output logic [W-1:0] idx
);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--)
      if (vec[i]) idx = W'(i);
  end

  assign found = |vec;
  // Clearing the lowest set bit leaves something only when two or more are set
  assign multi = |(vec & (vec - N'(1)));

endmodule

// File: rtl/tlb_array_mp.sv
// Multi-port fully associative TLB array with pseudo-random fill index and
// a group-at-a-time invalidate walker.
module tlb_array_mp
  import tlb_pkg::*;
#(
  parameter  int TLBNUM  = 32,
  parameter  int NPORT   = 2,
  parameter  int INV_GRP = 8,
  localparam int IW      = $clog2(TLBNUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORT-1:0]               s_fetch,
  input  logic [NPORT-1:0][VPPN_W-1:0]   s_vppn,
  input  logic [NPORT-1:0]               s_odd_page,
  input  logic [NPORT-1:0][ASID_W-1:0]   s_asid,
  output logic [NPORT-1:0]               s_found,
  output logic [NPORT-1:0]               s_multi,
  output logic [NPORT-1:0][IW-1:0]       s_index,
  output logic [NPORT-1:0][RES_W-1:0]    s_res,
  input  logic                           we,
  input  logic                           w_rand,
  input  logic [IW-1:0]                  w_index,
  input  logic [ENTRY_W-1:0]             w_entry,
  output logic [IW-1:0]                  fill_index,
  input  logic [IW-1:0]                  r_index,
  output logic [ENTRY_W-1:0]             r_entry,
  input  logic                           inv_en,
  input  logic [4:0]                     inv_op,
  input  logic [ASID_W-1:0]              inv_asid,
  input  logic [VPPN_W-1:0]              inv_vpn,
  output logic                           inv_busy,
  output logic                           inv_done
);

  localparam int NGRP = TLBNUM / INV_GRP;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  tlb_entry_t        mem [TLBNUM];
  logic [TLBNUM-1:0] e_q;
  logic [IW-1:0]     fill_q;
  logic [IW-1:0]     w_idx;
  tlb_entry_t        w_ent;
  tlb_entry_t        r_ent;

  assign w_ent      = tlb_entry_t'(w_entry);
  assign w_idx      = w_rand ? fill_q : w_index;
  assign fill_index = fill_q;

  // Entry payload is not reset; only the valid bits live in e_q
  always_ff @(posedge clk)
    if (we) mem[w_idx] <= w_ent;

  always_comb begin
    r_ent   = mem[r_index];
    r_ent.e = e_q[r_index];
  end
  assign r_entry = r_ent;

  always_ff @(posedge clk or posedge rst)
    if (rst) fill_q <= '0;
    else     fill_q <= fill_q + 1'b1;

  // ---------------- invalidate walker ----------------
  inv_state_t        st_q, st_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic              done_q, done_d;
  logic [4:0]        op_q;
  logic [ASID_W-1:0] asid_q;
  logic [VPPN_W-1:0] vpn_q;
  logic [TLBNUM-1:0] kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= INV_IDLE;
      grp_q  <= '0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      grp_q  <= grp_d;
      done_q <= done_d;
    end
  end

  always_ff @(posedge clk)
    if (st_q == INV_IDLE && inv_en) begin
      op_q   <= inv_op;
      asid_q <= inv_asid;
      vpn_q  <= inv_vpn;
    end

  always_comb begin
    st_d   = st_q;
    grp_d  = grp_q;
    done_d = 1'b0;
    case (st_q)
      INV_IDLE:
        if (inv_en) begin
          if (inv_op <= INV_OP_GASID_VA) begin
            st_d  = INV_WALK;
            grp_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      INV_WALK:
        if (grp_q == GW'(NGRP - 1)) begin
          st_d   = INV_IDLE;
          grp_d  = '0;
          done_d = 1'b1;
        end else begin
          grp_d = grp_q + 1'b1;
        end
      default: st_d = INV_IDLE;
    endcase
  end

  always_comb begin
    inv_busy = (st_q == INV_WALK);
    inv_done = done_q;
  end

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      logic asid_m, va_m, rule;
      asid_m = (mem[i].asid == asid_q);
      va_m   = vpn_match(mem[i].ps, mem[i].vppn, vpn_q);
      case (op_q)
        INV_OP_ALL0, INV_OP_ALL1: rule = 1'b1;
        INV_OP_G1:                rule = mem[i].g;
        INV_OP_G0:                rule = !mem[i].g;
        INV_OP_G0_ASID:           rule = !mem[i].g && asid_m;
        INV_OP_G0_ASID_VA:        rule = !mem[i].g && asid_m && va_m;
        INV_OP_GASID_VA:          rule = (mem[i].g || asid_m) && va_m;
        default:                  rule = 1'b0;
      endcase
      kill[i] = (st_q == INV_WALK) && (grp_q == GW'(i / INV_GRP)) && rule;
    end
  end

  // A write landing on an entry being walked this cycle takes precedence
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_q <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && w_idx == IW'(i)) e_q[i] <= w_ent.e;
        else if (kill[i])          e_q[i] <= 1'b0;
      end
    end
  end

  // ---------------- search ports ----------------
  logic [NPORT-1:0][TLBNUM-1:0] hit;
  logic [NPORT-1:0]             pe_found;
  logic [NPORT-1:0]             pe_multi;
  logic [NPORT-1:0][IW-1:0]     pe_idx;
  tlb_res_t [NPORT-1:0]         res_d;

  always_comb begin
    for (int p = 0; p < NPORT; p++)
      for (int i = 0; i < TLBNUM; i++)
        hit[p][i] = e_q[i] && (mem[i].g || mem[i].asid == s_asid[p]) &&
                    vpn_match(mem[i].ps, mem[i].vppn, s_vppn[p]);
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    tlb_prio_enc #(.N(TLBNUM)) u_pe (
      .vec   (hit[p]),
      .found (pe_found[p]),
      .multi (pe_multi[p]),
      .idx   (pe_idx[p])
    );
  end

  // Large pages pick the half with VA bit 21, i.e. vppn[8]
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      tlb_entry_t sel;
      logic       odd;
      sel      = mem[pe_idx[p]];
      odd      = (sel.ps == PS_4K) ? s_odd_page[p] : s_vppn[p][8];
      res_d[p] = odd ? half_res(sel.ps, sel.p1) : half_res(sel.ps, sel.p0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_found <= '0;
      s_multi <= '0;
      s_index <= '0;
      s_res   <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++)
        if (s_fetch[p]) begin
          s_found[p] <= pe_found[p];
          s_multi[p] <= pe_multi[p];
          if (pe_found[p]) begin
            s_index[p] <= pe_idx[p];
            s_res[p]   <= res_d[p];
          end
        end
    end
  end

endmodule

// File: tb/tb_tlb_array_mp.sv
// Directed plus random checks of tlb_array_mp against a field-level model.
module tb_tlb_array_mp;

  localparam int TLBNUM = 32;
  localparam int NPORT  = 2;
  localparam int IW     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    rst;
  logic [NPORT-1:0]        s_fetch;
  logic [NPORT-1:0][18:0]  s_vppn;
  logic [NPORT-1:0]        s_odd_page;
  logic [NPORT-1:0][9:0]   s_asid;
  logic [NPORT-1:0]        s_found;
  logic [NPORT-1:0]        s_multi;
  logic [NPORT-1:0][IW-1:0] s_index;
  logic [NPORT-1:0][31:0]  s_res;
  logic                    we, w_rand;
  logic [IW-1:0]           w_index;
  logic [88:0]             w_entry;
  logic [IW-1:0]           fill_index;
  logic [IW-1:0]           r_index;
  logic [88:0]             r_entry;
  logic                    inv_en;
  logic [4:0]              inv_op;
  logic [9:0]              inv_asid;
  logic [18:0]             inv_vpn;
  logic                    inv_busy, inv_done;

  tlb_array_mp #(.TLBNUM(TLBNUM), .NPORT(NPORT), .INV_GRP(8)) dut (
    .clk(clk), .rst(rst),
    .s_fetch(s_fetch), .s_vppn(s_vppn), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_multi(s_multi), .s_index(s_index), .s_res(s_res),
    .we(we), .w_rand(w_rand), .w_index(w_index), .w_entry(w_entry),
    .fill_index(fill_index), .r_index(r_index), .r_entry(r_entry),
    .inv_en(inv_en), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vpn(inv_vpn),
    .inv_busy(inv_busy), .inv_done(inv_done)
  );

  typedef struct packed {
    logic [18:0]      vppn;
    logic [9:0]       asid;
    logic             g;
    logic [5:0]       ps;
    logic             e;
    logic [1:0]       v;
    logic [1:0]       d;
    logic [1:0][1:0]  mat;
    logic [1:0][1:0]  plv;
    logic [1:0][19:0] ppn;
  } ment_t;

  int total = 0;
  int bad   = 0;

  // reference model state
  ment_t       m_mem [TLBNUM];
  bit          written [TLBNUM];
  int          m_fill;
  bit          m_busy, m_done;
  int          m_grp;
  int          m_op;
  logic [9:0]  m_iasid;
  logic [18:0] m_ivpn;
  logic        m_found [NPORT];
  logic        m_multi [NPORT];
  int          m_idx   [NPORT];
  logic [31:0] m_res   [NPORT];
  ment_t       w_s;

  function automatic logic [88:0] pack(input ment_t m);
    return {m.vppn, m.asid, m.g, m.ps, m.e,
            m.v[0], m.d[0], m.mat[0], m.plv[0], m.ppn[0],
            m.v[1], m.d[1], m.mat[1], m.plv[1], m.ppn[1]};
  endfunction

  function automatic ment_t mk(input logic [18:0] vppn, input logic [9:0] asid, input logic g,
                               input logic [5:0] ps, input logic [19:0] p0, input logic [19:0] p1);
    ment_t m;
    m.vppn = vppn; m.asid = asid; m.g = g; m.ps = ps; m.e = 1'b1;
    m.v = 2'b11; m.d = 2'b01;
    m.mat[0] = 2'd1; m.mat[1] = 2'd2;
    m.plv[0] = 2'd0; m.plv[1] = 2'd3;
    m.ppn[0] = p0;   m.ppn[1] = p1;
    return m;
  endfunction

  function automatic bit va_ok(input ment_t m, input logic [18:0] v);
    if (m.ps == 6'd12) return m.vppn == v;
    return m.vppn[18:9] == v[18:9];
  endfunction

  function automatic bit inv_rule(input ment_t m, input int op, input logic [9:0] a, input logic [18:0] v);
    bit am = (m.asid == a);
    case (op)
      0, 1:    return 1'b1;
      2:       return m.g;
      3:       return !m.g;
      4:       return !m.g && am;
      5:       return !m.g && am && va_ok(m, v);
      6:       return (m.g || am) && va_ok(m, v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("fill_index", 128'(fill_index), 128'(m_fill));
    check("inv_busy", 128'(inv_busy), 128'(m_busy));
    check("inv_done", 128'(inv_done), 128'(m_done));
    for (int p = 0; p < NPORT; p++) begin
      check($sformatf("found%0d", p), 128'(s_found[p]), 128'(m_found[p]));
      check($sformatf("multi%0d", p), 128'(s_multi[p]), 128'(m_multi[p]));
      check($sformatf("index%0d", p), 128'(s_index[p]), 128'(m_idx[p]));
      check($sformatf("res%0d", p),   128'(s_res[p]),   128'(m_res[p]));
    end
    if (written[r_index])
      check("r_entry", 128'(r_entry), 128'(pack(m_mem[r_index])));
  endtask

  // Advance one clock: model consumes the inputs now driven, then compare
  task automatic cyc();
    if (rst) begin
      for (int i = 0; i < TLBNUM; i++) m_mem[i].e = 1'b0;
      m_fill = 0; m_busy = 0; m_done = 0; m_grp = 0;
      for (int p = 0; p < NPORT; p++) begin
        m_found[p] = 0; m_multi[p] = 0; m_idx[p] = 0; m_res[p] = '0;
      end
    end else begin
      bit nd = 0;
      for (int p = 0; p < NPORT; p++) begin
        if (s_fetch[p]) begin
          int cnt = 0;
          int first = 0;
          for (int i = 0; i < TLBNUM; i++)
            if (m_mem[i].e && (m_mem[i].g || m_mem[i].asid == s_asid[p]) && va_ok(m_mem[i], s_vppn[p])) begin
              if (cnt == 0) first = i;
              cnt++;
            end
          m_found[p] = (cnt > 0);
          m_multi[p] = (cnt > 1);
          if (cnt > 0) begin
            ment_t m = m_mem[first];
            int o = (m.ps == 6'd12) ? int'(s_odd_page[p]) : int'(s_vppn[p][8]);
            m_idx[p] = first;
            m_res[p] = {m.ps, m.ppn[o], m.v[o], m.d[o], m.mat[o], m.plv[o]};
          end
        end
      end
      if (m_busy) begin
        for (int i = m_grp * 8; i < m_grp * 8 + 8; i++)
          if (inv_rule(m_mem[i], m_op, m_iasid, m_ivpn)) m_mem[i].e = 1'b0;
        if (m_grp == 3) begin m_busy = 0; nd = 1; end
        else m_grp++;
      end else if (inv_en) begin
        if (inv_op <= 5'd6) begin
          m_busy = 1; m_grp = 0; m_op = int'(inv_op); m_iasid = inv_asid; m_ivpn = inv_vpn;
        end else nd = 1;
      end
      if (we) begin
        int wi = w_rand ? m_fill : int'(w_index);
        m_mem[wi] = w_s;
        written[wi] = 1;
      end
      m_fill = (m_fill + 1) % TLBNUM;
      m_done = nd;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic wr(input int idx, input ment_t m);
    we = 1; w_rand = 0; w_index = IW'(idx); w_entry = pack(m); w_s = m;
    cyc();
    we = 0;
  endtask

  task automatic srch(input int p, input logic [18:0] v, input logic odd, input logic [9:0] a);
    s_fetch[p] = 1'b1; s_vppn[p] = v; s_odd_page[p] = odd; s_asid[p] = a;
  endtask

  function automatic ment_t rnd_ent();
    ment_t m;
    m.vppn = {($urandom_range(0, 1) ? 10'h100 : 10'h101), 9'($urandom_range(0, 2) == 0 ? 9'h1FF : 9'($urandom_range(0, 1)))};
    m.asid = 10'($urandom_range(1, 2));
    m.g    = 1'($urandom);
    m.ps   = $urandom_range(0, 1) ? 6'd12 : 6'd21;
    m.e    = ($urandom_range(0, 7) != 0);
    m.v    = 2'($urandom); m.d = 2'($urandom);
    m.mat  = 4'($urandom); m.plv = 4'($urandom);
    m.ppn[0] = 20'($urandom); m.ppn[1] = 20'($urandom);
    return m;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, nd, k;
    ment_t a, b, c;
    for (int i = 0; i < TLBNUM; i++) written[i] = 0;
    rst = 1; s_fetch = '0; s_vppn = '0; s_odd_page = '0; s_asid = '0;
    we = 0; w_rand = 0; w_index = '0; w_entry = '0; r_index = '0;
    inv_en = 0; inv_op = '0; inv_asid = '0; inv_vpn = '0;
    cyc(); cyc();
    check("reset_found", 128'(s_found), 128'(0));
    rst = 0;
    cyc();

    // single hit on odd 4K half
    wr(5, mk(19'h12345, 10'd3, 1'b0, 6'd12, 20'h11111, 20'hABCDE));
    srch(1, 19'h12345, 1'b1, 10'd3);
    cyc(); s_fetch = '0;
    check("t040_found", 128'(s_found[1]), 128'(1));
    check("t040_index", 128'(s_index[1]), 128'(5));
    check("t040_ppn",   128'(s_res[1][25:6]), 128'(20'hABCDE));

    // duplicate entries, both ports
    wr(2, mk(19'h22222, 10'd4, 1'b0, 6'd12, 20'h1, 20'h2));
    wr(9, mk(19'h22222, 10'd4, 1'b0, 6'd12, 20'h1, 20'h2));
    srch(0, 19'h22222, 1'b0, 10'd4);
    srch(1, 19'h22222, 1'b0, 10'd4);
    cyc(); s_fetch = '0;
    check("t041_idx0",   128'(s_index[0]), 128'(2));
    check("t041_idx1",   128'(s_index[1]), 128'(2));
    check("t041_multi0", 128'(s_multi[0]), 128'(1));
    check("t041_multi1", 128'(s_multi[1]), 128'(1));

    // large page, half chosen by vppn[8]
    wr(12, mk(19'h40100, 10'd7, 1'b0, 6'd21, 20'h33333, 20'h44444));
    srch(0, 19'h401FF, 1'b0, 10'd7);
    cyc(); s_fetch = '0;
    check("t042_found", 128'(s_found[0]), 128'(1));
    check("t042_index", 128'(s_index[0]), 128'(12));
    check("t042_ppn",   128'(s_res[0][25:6]), 128'(20'h44444));
    check("t042_ps",    128'(s_res[0][31:26]), 128'(21));

    // fill all, invalidate global entries
    for (int i = 0; i < TLBNUM; i++)
      wr(i, mk(19'h50000 + 19'(i), 10'd1, 1'(i % 2), 6'd12, 20'(i), 20'(i + 256)));
    inv_en = 1; inv_op = 5'd2;
    cyc(); inv_en = 0;
    nb = 0; nd = 0;
    for (int j = 0; j < 8; j++) begin
      if (inv_busy) nb++;
      if (inv_done) nd++;
      cyc();
    end
    check("t043_busy_cycles", 128'(nb), 128'(4));
    check("t043_done_pulses", 128'(nd), 128'(1));
    for (int i = 0; i < 8; i++) begin
      srch(0, 19'h50000 + 19'(i), 1'b0, 10'd1);
      cyc(); s_fetch = '0;
      check($sformatf("t043_hit%0d", i), 128'(s_found[0]), 128'(i % 2 == 0));
    end

    // unsupported op: immediate done, no walk
    inv_en = 1; inv_op = 5'd9;
    cyc(); inv_en = 0;
    check("t044_nop_done", 128'(inv_done), 128'(1));
    check("t044_nop_busy", 128'(inv_busy), 128'(0));
    cyc();

    // reset during a clear-all walk
    inv_en = 1; inv_op = 5'd0;
    cyc(); inv_en = 0;
    cyc();
    rst = 1;
    #1;
    check("t044_async_busy", 128'(inv_busy), 128'(0));
    cyc();
    rst = 0;
    nd = 0;
    for (int j = 0; j < 6; j++) begin
      cyc();
      if (inv_done) nd++;
    end
    check("t044_no_done", 128'(nd), 128'(0));
    r_index = 5'd30;
    #1;
    check("t044_e_cleared", 128'(r_entry[52]), 128'(0));

    // random-index writes across the wrap
    k = 0;
    while (fill_index != 5'd30 && k < 64) begin cyc(); k++; end
    check("t045_reach", 128'(fill_index), 128'(30));
    a = mk(19'h61111, 10'd5, 1'b1, 6'd12, 20'hA, 20'hAA);
    b = mk(19'h62222, 10'd5, 1'b0, 6'd21, 20'hB, 20'hBB);
    c = mk(19'h63333, 10'd6, 1'b1, 6'd12, 20'hC, 20'hCC);
    we = 1; w_rand = 1;
    w_entry = pack(a); w_s = a; cyc();
    w_entry = pack(b); w_s = b; cyc();
    w_entry = pack(c); w_s = c; cyc();
    we = 0; w_rand = 0;
    r_index = 5'd30; #1; check("t045_idx30", 128'(r_entry), 128'(pack(a)));
    r_index = 5'd31; #1; check("t045_idx31", 128'(r_entry), 128'(pack(b)));
    r_index = 5'd0;  #1; check("t045_idx0",  128'(r_entry), 128'(pack(c)));

    // random traffic
    for (int n = 0; n < 400; n++) begin
      ment_t m = rnd_ent();
      we = ($urandom_range(0, 2) == 0);
      w_rand = 1'($urandom);
      w_index = IW'($urandom);
      w_entry = pack(m); w_s = m;
      inv_en = ($urandom_range(0, 15) == 0);
      inv_op = 5'($urandom_range(0, 10));
      inv_asid = 10'($urandom_range(1, 2));
      inv_vpn = {($urandom_range(0, 1) ? 10'h100 : 10'h101), 9'($urandom_range(0, 1))};
      r_index = IW'($urandom);
      for (int p = 0; p < NPORT; p++) begin
        s_fetch[p] = 1'($urandom);
        s_vppn[p] = {($urandom_range(0, 1) ? 10'h100 : 10'h101),
                     ($urandom_range(0, 2) == 0 ? 9'h1FF : 9'($urandom_range(0, 1)))};
        s_odd_page[p] = 1'($urandom);
        s_asid[p] = 10'($urandom_range(1, 2));
      end
      cyc();
    end
    we = 0; inv_en = 0; s_fetch = '0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
